// File: rtl/edge_frame_sequencer_if.sv
// edge_frame_sequencer_if: frame control, frame-buffer read and
// sync timing signals between the sequencer and the edge pipeline.
interface edge_frame_sequencer_if #(
    parameter int ADDR_W = 17
);
    logic              i_start;
    logic              i_abort;
    logic              o_busy;
    logic              o_done;
    logic              o_err;
    logic              o_rd_en;
    logic [ADDR_W-1:0] o_rd_addr;
    logic              o_vsync;
    logic              o_hsync;
    logic              o_de;
    logic              i_pipe_de;

    modport master (
        input  i_start, i_abort, i_pipe_de,
        output o_busy, o_done, o_err, o_rd_en, o_rd_addr,
        output o_vsync, o_hsync, o_de
    );

    modport slave (
        output i_start, i_abort, i_pipe_de,
        input  o_busy, o_done, o_err, o_rd_en, o_rd_addr,
        input  o_vsync, o_hsync, o_de
    );
endinterface

// File: rtl/edge_frame_sequencer.sv
// edge_frame_sequencer: raster read-out and sync generation for one
// frame, with tail return counting, drain wait and error reporting.
module edge_frame_sequencer #(
    parameter int IMG_W     = 320,
    parameter int IMG_H     = 240,
    parameter int V_PULSE   = 4,
    parameter int H_PULSE   = 2,
    parameter int H_BACK    = 2,
    parameter int DRAIN_MAX = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    edge_frame_sequencer_if.master bus
);
    localparam int ADDR_W = $clog2(IMG_W * IMG_H);
    localparam logic [31:0] NPIX = 32'(IMG_W * IMG_H);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VSYNC,
        S_HSYNC,
        S_HBACK,
        S_ACTIVE,
        S_DRAIN
    } state_t;

    state_t      state;
    logic [31:0] cnt;
    logic [31:0] line;
    logic [31:0] ret;
    logic        err_r;
    logic        done_r;
    logic        ret_full;
    logic        ret_last;

    assign ret_full = (ret == NPIX);
    assign ret_last = ret_full || ((ret == NPIX - 32'd1) && bus.i_pipe_de);

    // Frame FSM with state-aligned read strobe/address and return counting.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            cnt           <= '0;
            line          <= '0;
            ret           <= '0;
            err_r         <= 1'b0;
            done_r        <= 1'b0;
            bus.o_rd_en   <= 1'b0;
            bus.o_rd_addr <= '0;
        end else begin
            done_r <= 1'b0;
            if (state != S_IDLE && bus.i_pipe_de) begin
                if (ret_full)
                    err_r <= 1'b1;
                else
                    ret <= ret + 32'd1;
            end
            if (bus.i_abort) begin
                state       <= S_IDLE;
                cnt         <= '0;
                bus.o_rd_en <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (bus.i_start) begin
                            state         <= S_VSYNC;
                            cnt           <= '0;
                            line          <= '0;
                            ret           <= '0;
                            err_r         <= 1'b0;
                            bus.o_rd_addr <= '0;
                        end
                    end
                    S_VSYNC: begin
                        if (cnt == 32'(V_PULSE - 1)) begin
                            state <= S_HSYNC;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 32'd1;
                        end
                    end
                    S_HSYNC: begin
                        if (cnt == 32'(H_PULSE - 1)) begin
                            cnt <= '0;
                            if (H_BACK == 0) begin
                                state       <= S_ACTIVE;
                                bus.o_rd_en <= 1'b1;
                            end else begin
                                state <= S_HBACK;
                            end
                        end else begin
                            cnt <= cnt + 32'd1;
                        end
                    end
                    S_HBACK: begin
                        if (cnt == 32'(H_BACK - 1)) begin
                            state       <= S_ACTIVE;
                            cnt         <= '0;
                            bus.o_rd_en <= 1'b1;
                        end else begin
                            cnt <= cnt + 32'd1;
                        end
                    end
                    S_ACTIVE: begin
                        if (cnt == 32'(IMG_W - 1)) begin
                            cnt         <= '0;
                            bus.o_rd_en <= 1'b0;
                            if (line == 32'(IMG_H - 1)) begin
                                state <= S_DRAIN;
                            end else begin
                                state         <= S_HSYNC;
                                line          <= line + 32'd1;
                                bus.o_rd_addr <= bus.o_rd_addr + ADDR_W'(1);
                            end
                        end else begin
                            cnt           <= cnt + 32'd1;
                            bus.o_rd_addr <= bus.o_rd_addr + ADDR_W'(1);
                        end
                    end
                    S_DRAIN: begin
                        if (ret_last) begin
                            state  <= S_IDLE;
                            cnt    <= '0;
                            done_r <= 1'b1;
                        end else if (cnt == 32'(DRAIN_MAX - 1)) begin
                            state  <= S_IDLE;
                            cnt    <= '0;
                            err_r  <= 1'b1;
                            done_r <= 1'b1;
                        end else begin
                            cnt <= cnt + 32'd1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // Status and sync outputs trail the FSM by one cycle to line up with read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.o_busy  <= 1'b0;
            bus.o_done  <= 1'b0;
            bus.o_err   <= 1'b0;
            bus.o_vsync <= 1'b0;
            bus.o_hsync <= 1'b0;
            bus.o_de    <= 1'b0;
        end else if (bus.i_abort) begin
            bus.o_busy  <= 1'b0;
            bus.o_done  <= 1'b0;
            bus.o_err   <= err_r;
            bus.o_vsync <= 1'b0;
            bus.o_hsync <= 1'b0;
            bus.o_de    <= 1'b0;
        end else begin
            bus.o_busy  <= (state != S_IDLE);
            bus.o_done  <= done_r;
            bus.o_err   <= err_r;
            bus.o_vsync <= (state == S_VSYNC);
            bus.o_hsync <= (state == S_HSYNC);
            bus.o_de    <= bus.o_rd_en;
        end
    end
endmodule
